// File: rtl/bootram_ctrl.sv
// Purpose: sequences four 2kx8 boot RAM byte lanes behind the PicoRV32 native bus, arbitrated against a byte-stream loader.
// Latency: CPU read and write are acknowledged 2 clocks after mem_valid; the loader runs at 1 byte/clk with ld_ready one clock after the byte.
// Backpressure: the loader owns the RAM while ld_en is high and a CPU request waits until ld_en drops; optional macro BOOTRAM_WRITE_PROTECT_EN blocks CPU writes.
module bootram_ctrl #(
    parameter int ADDR_W   = 11,
    parameter int LD_CNT_W = 13
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mem_valid,
    input  logic                mem_sel,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_wdata,
    input  logic [3:0]          mem_wstrb,
    output logic                mem_ready,
    output logic [31:0]         mem_rdata,
    input  logic                ld_en,
    input  logic                ld_valid,
    input  logic [7:0]          ld_data,
    output logic                ld_ready,
    output logic [LD_CNT_W-1:0] ld_count,
    output logic                ld_wrap,
    output logic [3:0]          ram_ce,
    output logic [3:0]          ram_wre,
    output logic                ram_oce,
    output logic                ram_reset,
    output logic [ADDR_W-1:0]   ram_ad,
    output logic [31:0]         ram_din,
    input  logic [31:0]         ram_dout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WACK = 2'd2
    } state_t;

    state_t              state;
    logic                ld_en_q;
    logic                rd_ack;
    logic [31:0]         rdata_q;
    logic                ld_rise;
    logic                cpu_req;
    logic [LD_CNT_W-1:0] ld_base;
    logic [3:0]          ld_lane;

    assign ram_oce   = 1'b1;
    assign ram_reset = reset;

    // The lane output is only valid in the acknowledge cycle that follows RD, so pass it straight through then and hold the last word otherwise.
    assign mem_rdata = rd_ack ? ram_dout : rdata_q;

    // Byte address used by a loader write this cycle; a fresh ld_en rise restarts at address 0.
    always_comb begin
        ld_rise = ld_en & ~ld_en_q;
        ld_base = ld_rise ? '0 : ld_count;
        ld_lane = 4'(4'b0001 << ld_base[1:0]);
        // mem_ready is high for the single cycle in which the CPU still holds mem_valid for the finished transfer, so do not restart it.
        cpu_req = mem_valid & mem_sel & ~mem_ready;
    end

`ifdef BOOTRAM_WRITE_PROTECT_EN
    logic unused_sig;
    assign unused_sig = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0], mem_wdata};
`else
    logic unused_sig;
    assign unused_sig = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};
`endif

    // Single FSM: arbitration, RAM strobes, handshakes and loader counter, all registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ld_en_q   <= 1'b0;
            rd_ack    <= 1'b0;
            rdata_q   <= '0;
            mem_ready <= 1'b0;
            ld_ready  <= 1'b0;
            ld_count  <= '0;
            ld_wrap   <= 1'b0;
            ram_ce    <= '0;
            ram_wre   <= '0;
            ram_ad    <= '0;
            ram_din   <= '0;
        end else begin
            ld_en_q   <= ld_en;
            mem_ready <= 1'b0;
            rd_ack    <= 1'b0;
            ld_ready  <= 1'b0;
            ram_ce    <= '0;
            ram_wre   <= '0;

            if (rd_ack) begin
                rdata_q <= ram_dout;
            end

            if (ld_rise) begin
                ld_count <= '0;
                ld_wrap  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (ld_en) begin
                        if (ld_valid) begin
                            ram_ce   <= ld_lane;
                            ram_wre  <= ld_lane;
                            ram_ad   <= ld_base[LD_CNT_W-1:2];
                            ram_din  <= {4{ld_data}};
                            ld_ready <= 1'b1;
                            ld_count <= ld_base + LD_CNT_W'(1);
                            if (&ld_base) begin
                                ld_wrap <= 1'b1;
                            end
                        end
                    end else if (cpu_req) begin
                        ram_ad <= mem_addr[ADDR_W+1:2];
                        if (mem_wstrb == 4'b0000) begin
                            ram_ce <= 4'hF;
                            state  <= RD;
                        end else begin
`ifdef BOOTRAM_WRITE_PROTECT_EN
                            ram_ce  <= 4'h0;
                            ram_wre <= 4'h0;
`else
                            ram_ce  <= mem_wstrb;
                            ram_wre <= mem_wstrb;
                            ram_din <= mem_wdata;
`endif
                            state   <= WACK;
                        end
                    end
                end
                RD: begin
                    mem_ready <= 1'b1;
                    rd_ack    <= 1'b1;
                    state     <= IDLE;
                end
                WACK: begin
                    mem_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
